// File: rtl/adc_frame_serializer.sv
// adc_frame_serializer
// Turns parallel multi-lane sample frames into per-lane MSB-first serial streams.
// A frame clock runs high during the first half of every frame.
// One holding register decouples the source from the shifter, so frames can stream back-to-back.
// Every output is derived from registers only, so no input reaches an output combinationally.
//
// state | meaning
// IDLE  | shifter empty; lanes and frame clock driven low
// SHIFT | one bit per lane per cycle; bit_idx counts 0..DATA_WIDTH-1
module adc_frame_serializer #(
  parameter int DATA_WIDTH   = 12,
  parameter int NUM_CHANNELS = 16,
  parameter int CNT_WIDTH    = 16
) (
  input  logic                               clk,
  input  logic                               reset_n,
  input  logic [NUM_CHANNELS*DATA_WIDTH-1:0] s_data,
  input  logic                               s_valid,
  output logic                               s_ready,
  input  logic                               stream_en,
  input  logic                               clear_err,
  output logic [NUM_CHANNELS-1:0]            ser_data_out,
  output logic                               ser_frame_clk,
  output logic                               busy,
  output logic                               underrun,
  output logic [CNT_WIDTH-1:0]               frames_sent
);

  localparam int FW    = NUM_CHANNELS * DATA_WIDTH;
  localparam int IDX_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_WIDTH - 1);
  localparam logic [IDX_W-1:0] HALF_IDX = IDX_W'(DATA_WIDTH / 2);

  typedef enum logic {IDLE = 1'b0, SHIFT = 1'b1} state_t;

  state_t               state_q, state_d;
  logic [FW-1:0]        hold_q, hold_d;
  logic [FW-1:0]        shift_q, shift_d;
  logic                 hold_full_q, hold_full_d;
  logic [IDX_W-1:0]     bit_idx_q, bit_idx_d;
  logic                 underrun_q, underrun_d;
  logic [CNT_WIDTH-1:0] frames_q, frames_d;

  logic handshake;
  logic last_bit;
  logic load;

  // The ready flag is simply the inverse of the holding-register occupancy flop.
  assign s_ready     = ~hold_full_q;
  assign handshake   = s_valid & ~hold_full_q;
  assign last_bit    = (state_q == SHIFT) && (bit_idx_q == LAST_IDX);
  // Load happens from IDLE, or gaplessly at the last bit when the next frame is already waiting.
  assign load        = hold_full_q & ((state_q == IDLE) | last_bit);
  assign underrun    = underrun_q;
  assign frames_sent = frames_q;

  // State register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic: leave IDLE once a frame is held, return only when the source runs dry.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (hold_full_q) state_d = SHIFT;
      SHIFT:   if (last_bit && !hold_full_q) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Output logic: lanes show the shifter MSBs only while shifting.
  always_comb begin
    busy          = (state_q == SHIFT);
    ser_frame_clk = (state_q == SHIFT) && (bit_idx_q < HALF_IDX);
    ser_data_out  = '0;
    for (int k = 0; k < NUM_CHANNELS; k++) begin
      ser_data_out[k] = (state_q == SHIFT) & shift_q[k*DATA_WIDTH + DATA_WIDTH - 1];
    end
  end

  // Datapath next values: holding register, shifter, bit index, counter and sticky flag.
  always_comb begin
    hold_d      = hold_q;
    hold_full_d = hold_full_q;
    shift_d     = shift_q;
    bit_idx_d   = bit_idx_q;
    frames_d    = frames_q;
    underrun_d  = underrun_q;

    // handshake requires an empty hold and load a full one, so they never coincide.
    if (handshake) begin
      hold_d      = s_data;
      hold_full_d = 1'b1;
    end

    if (load) begin
      shift_d     = hold_q;
      bit_idx_d   = '0;
      hold_full_d = 1'b0;
    end else if ((state_q == SHIFT) && !last_bit) begin
      bit_idx_d = bit_idx_q + IDX_W'(1);
      for (int k = 0; k < NUM_CHANNELS; k++) begin
        shift_d[k*DATA_WIDTH +: DATA_WIDTH] = {shift_q[k*DATA_WIDTH +: DATA_WIDTH-1], 1'b0};
      end
    end

    // A new underrun overrides a simultaneous clear.
    if (clear_err) underrun_d = 1'b0;
    if (last_bit) begin
      frames_d = frames_q + CNT_WIDTH'(1);
      if (!hold_full_q && stream_en) underrun_d = 1'b1;
    end
  end

  // Datapath registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      hold_q      <= '0;
      hold_full_q <= 1'b0;
      shift_q     <= '0;
      bit_idx_q   <= '0;
      frames_q    <= '0;
      underrun_q  <= 1'b0;
    end else begin
      hold_q      <= hold_d;
      hold_full_q <= hold_full_d;
      shift_q     <= shift_d;
      bit_idx_q   <= bit_idx_d;
      frames_q    <= frames_d;
      underrun_q  <= underrun_d;
    end
  end

endmodule

// File: tb/tb_adc_frame_serializer.sv
// Testbench for adc_frame_serializer: randomized frames against a frame-level reference
// (queue of accepted frames, deserializer keyed on the frame clock rising edge).
// A narrow frame counter is used so that its wraparound is reachable in a short run.
module tb_adc_frame_serializer;
  localparam int DW = 12;
  localparam int NC = 16;
  localparam int CW = 10;
  localparam int FW = NC * DW;

  logic          clk;
  logic          reset_n;
  logic [FW-1:0] s_data;
  logic          s_valid;
  logic          s_ready;
  logic          stream_en;
  logic          clear_err;
  logic [NC-1:0] ser_data_out;
  logic          ser_frame_clk;
  logic          busy;
  logic          underrun;
  logic [CW-1:0] frames_sent;

  adc_frame_serializer #(.DATA_WIDTH(DW), .NUM_CHANNELS(NC), .CNT_WIDTH(CW)) dut (
    .clk(clk), .reset_n(reset_n), .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
    .stream_en(stream_en), .clear_err(clear_err), .ser_data_out(ser_data_out),
    .ser_frame_clk(ser_frame_clk), .busy(busy), .underrun(underrun), .frames_sent(frames_sent)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_pass  = 0;
  int n_total = 0;
  int fs_model = 0;

  // reference model state
  logic [FW-1:0] exp_q[$];
  logic [FW-1:0] rx_q[$];
  logic [FW-1:0] col_flat;
  int            col_idx;
  bit            collecting;
  logic          prev_fclk;
  // samples of the cycle just completed
  logic          smp_hs, smp_busy, smp_ready, smp_ready_prev, smp_rise;
  logic          smp_underrun, smp_underrun_prev;
  logic [CW-1:0] smp_fs, smp_fs_prev;
  bit            saw_wrap;

  function automatic logic [FW-1:0] rand_frame();
    logic [FW-1:0] f;
    for (int k = 0; k < NC; k++) f[k*DW +: DW] = DW'($urandom);
    return f;
  endfunction

  task automatic model_clear();
    exp_q.delete();
    rx_q.delete();
    collecting     = 0;
    col_idx        = 0;
    prev_fclk      = 1'b0;
    smp_ready      = 1'b1;
    smp_underrun   = underrun;
    smp_fs         = frames_sent;
    saw_wrap       = 0;
  endtask

  // One clock: sample outputs mid-cycle, feed the model, then advance to just after the edge.
  task automatic step();
    @(negedge clk);
    smp_hs            = s_valid && s_ready;
    if (smp_hs) exp_q.push_back(s_data);
    smp_ready_prev    = smp_ready;
    smp_ready         = s_ready;
    smp_busy          = busy;
    smp_underrun_prev = smp_underrun;
    smp_underrun      = underrun;
    smp_fs_prev       = smp_fs;
    smp_fs            = frames_sent;
    if (smp_fs_prev == '1 && smp_fs == '0) saw_wrap = 1;
    smp_rise = ser_frame_clk && !prev_fclk;
    if (smp_rise) begin
      collecting = 1;
      col_idx    = 0;
    end
    if (collecting) begin
      for (int k = 0; k < NC; k++)
        col_flat[k*DW +: DW] = {col_flat[k*DW +: DW-1], ser_data_out[k]};
      col_idx++;
      if (col_idx == DW) begin
        rx_q.push_back(col_flat);
        collecting = 0;
      end
    end
    prev_fclk = ser_frame_clk;
    @(posedge clk);
    #1;
  endtask

  task automatic drain(input int budget, output bit ok);
    ok = 0;
    for (int i = 0; i < budget; i++) begin
      step();
      if (!smp_busy && smp_ready) begin
        ok = 1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    int  hs;
    bit  seen;
    reset_n = 1'b0; s_valid = 1'b0; s_data = '0; stream_en = 1'b0; clear_err = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    n_total++; if ({s_ready, busy, ser_frame_clk, underrun} !== 4'b1000) $display("FAIL reset_ctrl: got %b expected 1000", {s_ready, busy, ser_frame_clk, underrun}); else n_pass++;
    n_total++; if (ser_data_out !== '0 || frames_sent !== '0) $display("FAIL reset_data: got %h/%h expected 0/0", ser_data_out, frames_sent); else n_pass++;
    reset_n = 1'b1;
    model_clear();
    // one frame shifting and a second one held, then reset mid-frame
    s_valid = 1'b1; s_data = rand_frame(); hs = 0;
    for (int i = 0; i < 20 && hs < 2; i++) begin
      step();
      if (smp_hs) begin hs++; s_data = rand_frame(); end
    end
    s_valid = 1'b0;
    repeat (3) step();
    n_total++; if (busy !== 1'b1 || s_ready !== 1'b0) $display("FAIL midreset_pre: got busy=%b ready=%b expected 1/0", busy, s_ready); else n_pass++;
    reset_n = 1'b0;
    #1;
    n_total++; if (ser_data_out !== '0 || ser_frame_clk !== 1'b0) $display("FAIL midreset_lanes: got %h/%b expected 0/0", ser_data_out, ser_frame_clk); else n_pass++;
    n_total++; if (busy !== 1'b0 || s_ready !== 1'b1 || frames_sent !== '0) $display("FAIL midreset_ctrl: got busy=%b ready=%b fs=%0d expected 0/1/0", busy, s_ready, frames_sent); else n_pass++;
    #2;
    reset_n = 1'b1;
    model_clear();
    seen = 0;
    repeat (30) begin step(); if (smp_busy) seen = 1; end
    n_total++; if (seen !== 1'b0 || frames_sent !== '0) $display("FAIL midreset_discard: got busy_seen=%b fs=%0d expected 0/0", seen, frames_sent); else n_pass++;
    fs_model = 0;
  endtask

  task automatic test_single();
    logic [FW-1:0] d;
    logic [DW-1:0] p0;
    logic [NC-1:0] ev;
    d = '0; p0 = 12'hA5C;
    d[0 +: DW] = p0;
    d[15*DW +: DW] = 12'h001;
    s_data = d; s_valid = 1'b1;
    @(posedge clk); #1;
    s_valid = 1'b0; s_data = rand_frame();
    n_total++; if (s_ready !== 1'b0 || busy !== 1'b0) $display("FAIL single_E0: got ready=%b busy=%b expected 0/0", s_ready, busy); else n_pass++;
    for (int c = 1; c <= DW; c++) begin
      @(posedge clk); @(negedge clk);
      ev = '0; ev[0] = p0[DW-c]; ev[15] = (c == DW);
      n_total++; if (ser_data_out !== ev) $display("FAIL single_bits c%0d: got %h expected %h", c, ser_data_out, ev); else n_pass++;
      n_total++; if (ser_frame_clk !== (c <= DW/2) || busy !== 1'b1) $display("FAIL single_fclk c%0d: got fclk=%b busy=%b expected %b/1", c, ser_frame_clk, busy, (c <= DW/2)); else n_pass++;
      if (c == 1) begin
        n_total++; if (s_ready !== 1'b1) $display("FAIL single_ready_E1: got %b expected 1", s_ready); else n_pass++;
      end
    end
    @(posedge clk); @(negedge clk);
    fs_model++;
    n_total++; if (busy !== 1'b0 || ser_data_out !== '0 || ser_frame_clk !== 1'b0) $display("FAIL single_idle: got busy=%b lanes=%h fclk=%b expected 0/0/0", busy, ser_data_out, ser_frame_clk); else n_pass++;
    n_total++; if (frames_sent !== CW'(fs_model) || underrun !== 1'b0) $display("FAIL single_count: got fs=%0d ur=%b expected %0d/0", frames_sent, underrun, fs_model); else n_pass++;
    @(posedge clk); #1;
  endtask

  task automatic test_back_to_back();
    int hs, busy_n, first, last, nrise;
    int rise_at[3];
    bit ok;
    model_clear();
    hs = 0; busy_n = 0; first = -1; last = -1; nrise = 0;
    s_valid = 1'b1; s_data = rand_frame();
    for (int cyc = 0; cyc < 80; cyc++) begin
      step();
      if (smp_hs) begin
        hs++;
        if (hs == 3) s_valid = 1'b0; else s_data = rand_frame();
      end
      if (smp_busy) begin
        if (first < 0) first = cyc;
        last = cyc;
        busy_n++;
      end
      if (smp_rise) begin
        if (nrise < 3) rise_at[nrise] = cyc;
        nrise++;
        n_total++; if ({smp_ready_prev, smp_ready} !== 2'b01) $display("FAIL b2b_ready_at_load %0d: got %b expected 01", nrise, {smp_ready_prev, smp_ready}); else n_pass++;
      end
    end
    s_valid = 1'b0;
    drain(50, ok);
    fs_model += 3;
    n_total++; if (busy_n !== 36 || (last - first + 1) !== 36) $display("FAIL b2b_contiguous: got %0d busy over span %0d expected 36/36", busy_n, last - first + 1); else n_pass++;
    n_total++; if (nrise !== 3) $display("FAIL b2b_rises: got %0d expected 3", nrise); else n_pass++;
    if (nrise == 3) begin
      n_total++; if (rise_at[1] - rise_at[0] !== DW || rise_at[2] - rise_at[1] !== DW) $display("FAIL b2b_period: got %0d,%0d expected %0d", rise_at[1] - rise_at[0], rise_at[2] - rise_at[1], DW); else n_pass++;
    end
    n_total++; if (!ok || rx_q.size() !== 3 || exp_q.size() !== 3) $display("FAIL b2b_frames: got rx=%0d acc=%0d ok=%0d expected 3/3/1", rx_q.size(), exp_q.size(), ok); else n_pass++;
    for (int i = 0; i < rx_q.size() && i < exp_q.size(); i++) begin
      n_total++; if (rx_q[i] !== exp_q[i]) $display("FAIL b2b_data %0d: got %h expected %h", i, rx_q[i], exp_q[i]); else n_pass++;
    end
    n_total++; if (frames_sent !== CW'(fs_model)) $display("FAIL b2b_count: got %0d expected %0d", frames_sent, fs_model); else n_pass++;
  endtask

  task automatic send_one_and_drain(output bit ok);
    bit got;
    got = 0;
    s_valid = 1'b1; s_data = rand_frame();
    for (int i = 0; i < 20 && !got; i++) begin
      step();
      if (smp_hs) got = 1;
    end
    s_valid = 1'b0;
    drain(40, ok);
    ok = ok & got;
  endtask

  task automatic test_underrun();
    bit ok;
    model_clear();
    stream_en = 1'b1; clear_err = 1'b0;
    n_total++; if (underrun !== 1'b0) $display("FAIL ur_initial: got %b expected 0", underrun); else n_pass++;
    send_one_and_drain(ok);
    n_total++; if (!ok || smp_underrun !== 1'b1 || smp_underrun_prev !== 1'b0) $display("FAIL ur_set: got ok=%0d ur=%b prev=%b expected 1/1/0", ok, smp_underrun, smp_underrun_prev); else n_pass++;
    clear_err = 1'b1;
    step();
    clear_err = 1'b0;
    n_total++; if (underrun !== 1'b0) $display("FAIL ur_clear: got %b expected 0", underrun); else n_pass++;
    repeat (6) step();
    n_total++; if (underrun !== 1'b0) $display("FAIL ur_idle_stream: got %b expected 0", underrun); else n_pass++;
    clear_err = 1'b1;
    send_one_and_drain(ok);
    n_total++; if (!ok || smp_underrun !== 1'b1) $display("FAIL ur_set_wins: got ok=%0d ur=%b expected 1/1", ok, smp_underrun); else n_pass++;
    step();
    clear_err = 1'b0;
    n_total++; if (underrun !== 1'b0) $display("FAIL ur_clear2: got %b expected 0", underrun); else n_pass++;
    stream_en = 1'b0;
    fs_model += 2;
    n_total++; if (frames_sent !== CW'(fs_model)) $display("FAIL ur_count: got %0d expected %0d", frames_sent, fs_model); else n_pass++;
  endtask

  task automatic check_stream(input string tag, input bit ok);
    n_total++; if (!ok || rx_q.size() !== exp_q.size()) $display("FAIL %s_sizes: got rx=%0d acc=%0d ok=%0d expected equal/1", tag, rx_q.size(), exp_q.size(), ok); else n_pass++;
    for (int i = 0; i < rx_q.size() && i < exp_q.size(); i++) begin
      n_total++; if (rx_q[i] !== exp_q[i]) $display("FAIL %s_data %0d: got %h expected %h", tag, i, rx_q[i], exp_q[i]); else n_pass++;
    end
    fs_model += exp_q.size();
    n_total++; if (frames_sent !== CW'(fs_model)) $display("FAIL %s_count: got %0d expected %0d", tag, frames_sent, CW'(fs_model)); else n_pass++;
  endtask

  task automatic test_loopback();
    localparam int N = 1100;
    int hs;
    bit ok;
    model_clear();
    hs = 0;
    s_valid = 1'b1; s_data = rand_frame();
    for (int cyc = 0; cyc < N*DW + 100 && hs < N; cyc++) begin
      step();
      if (smp_hs) begin
        hs++;
        if (hs == N) s_valid = 1'b0; else s_data = rand_frame();
      end
    end
    s_valid = 1'b0;
    n_total++; if (hs !== N) $display("FAIL loop_accepted: got %0d expected %0d", hs, N); else n_pass++;
    drain(100, ok);
    n_total++; if (exp_q.size() !== N) $display("FAIL loop_model_size: got %0d expected %0d", exp_q.size(), N); else n_pass++;
    check_stream("loop", ok);
    n_total++; if (saw_wrap !== 1'b1) $display("FAIL loop_wrap: got %0d expected 1", saw_wrap); else n_pass++;
  endtask

  task automatic test_backpressure();
    bit ok;
    bit sparse;
    model_clear();
    for (int cyc = 0; cyc < 2500; cyc++) begin
      sparse = (cyc / 500) % 2 == 1;
      s_valid = sparse ? ($urandom_range(0, 15) == 0) : ($urandom_range(0, 1) == 1);
      s_data  = rand_frame();
      step();
    end
    s_valid = 1'b0;
    drain(40, ok);
    n_total++; if (exp_q.size() < 20) $display("FAIL bp_activity: got %0d frames expected >= 20", exp_q.size()); else n_pass++;
    check_stream("bp", ok);
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_underrun();
    test_loopback();
    test_backpressure();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end
endmodule
